mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles waited for mem_valid per access.
REQ-002 Parameter DATA_W, default 16, data and address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction-fetch request, held until if_done.
REQ-006 if_addr  in  16  fetch address.
REQ-007 if_rdata  out  16  fetched instruction word, valid with if_done.
REQ-008 if_done  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request (LW/SW/LB class), held until d_done.
REQ-010 d_wr  in  1  1 = store, 0 = load; sampled at grant.
REQ-011 d_addr  in  16  data address.
REQ-012 d_wdata  in  16  store data.
REQ-013 d_rdata  out  16  load data, valid with d_done.
REQ-014 d_done  out  1  one-cycle data completion pulse.
REQ-015 mem_en, mem_wr, mem_addr[15:0], mem_wdata[15:0]  out  unified memory command.
REQ-016 mem_rdata  in  16, mem_valid  in  1  memory response; mem_valid is a one-cycle pulse.
REQ-017 stall  out  1  pipeline freeze request.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, IFETCH, DACC, TURN; reset state IDLE.
REQ-020 IDLE: only d_req -> DACC; only if_req -> IFETCH; both -> grant the port not served last (last_srv resets to FETCH, so data wins first); neither -> stay.
REQ-021 At grant, address, d_wr, and d_wdata are latched; mem_en=1 and mem_addr/mem_wr/mem_wdata are driven from the latches for every cycle in IFETCH/DACC; mem_en=0 in IDLE/TURN.
REQ-022 IFETCH, mem_valid=1: if_rdata<=mem_rdata, if_done=1 next cycle, last_srv<=FETCH, -> TURN.
REQ-023 DACC, mem_valid=1: d_rdata<=mem_rdata on loads (unchanged on stores), d_done=1 next cycle, last_srv<=DATA, -> TURN.
REQ-024 TURN lasts exactly one cycle, carries the done pulse, then -> IDLE; requester drops its req in this cycle; minimum access = grant + 1 memory cycle + TURN.
REQ-025 A wait counter clears at grant and increments each IFETCH/DACC cycle without mem_valid; reaching TIMEOUT-1 completes the access as if mem_valid with data 16'h0000 and sets err.
REQ-026 err clears only on rst.
REQ-027 mem_valid in IDLE or TURN is ignored.
REQ-028 mem_valid and timeout in the same cycle: mem_valid wins; err is not set.
REQ-029 Request inputs changing during IFETCH/DACC do not affect the access in flight.
REQ-030 stall = (if_req & ~if_done) | (d_req & ~d_done), combinational.
REQ-031 if_done and d_done are never high in the same cycle.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, last_srv=FETCH, counter=0, err=0, if_done=d_done=0, if_rdata=d_rdata=0, and latches cleared.
REQ-033 Reset mid-access abandons the access and produces no done pulse; mem_en=0 from the next cycle.

Structure
REQ-034 Package mem_arb_pkg holds the state enum, the FETCH/DATA port enum, and the DATA_W and TIMEOUT defaults.
REQ-035 One sub-module, arb_wait_cnt: the clearable timeout counter with a terminal-count output.

Verification
REQ-036 Fetch only: if_req, if_addr=16'h0040, mem_valid 3 cycles later with 16'hA123 -> if_rdata=16'hA123, one if_done pulse, stall low after.
REQ-037 Both requests raised 1 cycle after reset: d_req (load 16'h0100) and if_req -> data served first; fetch granted next; no overlapping done pulses.
REQ-038 Back-to-back contention for 4 accesses -> grants alternate DATA, FETCH, DATA, FETCH.
REQ-039 Store d_addr=16'h0200, d_wdata=16'hBEEF -> mem_wr=1, mem_wdata=16'hBEEF throughout DACC, d_rdata unchanged.
REQ-040 No mem_valid for 16 cycles -> completion at cycle 16, rdata=16'h0000, err=1 until rst.
REQ-041 rst asserted in the 2nd cycle of IFETCH -> no if_done, mem_en=0 next cycle, late mem_valid ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter.
//   state_t : arbiter FSM states
//   port_t  : which requester an access belongs to (FETCH / DATA)
//   DATA_W_DEF, TIMEOUT_DEF : default parameter values
package mem_arb_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2,
    TURN   = 2'd3
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } port_t;

endpackage

// File: rtl/arb_wait_cnt.sv
// Clearable wait counter used to bound how long an access waits for memory.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear the count (asserted at grant)
//   inc      : advance the count by one
//   tc       : terminal count, high while the count equals TIMEOUT-1
import mem_arb_pkg::*;

module arb_wait_cnt #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory.
//   if_req/if_addr -> if_rdata/if_done      : fetch requester
//   d_req/d_wr/d_addr/d_wdata -> d_rdata/d_done : data requester
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata/mem_valid : memory side
//   stall : pipeline freeze while any request is outstanding
//   err   : sticky flag, set when an access is ended by the timeout
// Each access is: grant (IDLE), one or more memory cycles (IFETCH/DACC),
// then a single TURN cycle carrying the done pulse.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              stall,
  output logic              err
);

  state_t            state_reg;
  port_t             last_srv_reg;
  logic [DATA_W-1:0] addr_reg;
  logic              wr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;
  logic              if_done_reg;
  logic              d_done_reg;
  logic              err_reg;

  logic busy;
  logic grant;
  logic tc;

  assign busy  = (state_reg == IFETCH) || (state_reg == DACC);
  assign grant = (state_reg == IDLE) && (if_req || d_req);

  // Counter stops at terminal count; the access ends that same cycle anyway.
  arb_wait_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_cnt (
    .clk(clk),
    .rst(rst),
    .clr(grant),
    .inc(busy && !mem_valid && !tc),
    .tc (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      last_srv_reg <= FETCH;
      addr_reg     <= '0;
      wr_reg       <= 1'b0;
      wdata_reg    <= '0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
      if_done_reg  <= 1'b0;
      d_done_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if_done_reg <= 1'b0;
      d_done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // On contention the port not served last wins.
          if (d_req && (!if_req || last_srv_reg == FETCH)) begin
            state_reg <= DACC;
            addr_reg  <= d_addr;
            wr_reg    <= d_wr;
            wdata_reg <= d_wdata;
          end else if (if_req) begin
            state_reg <= IFETCH;
            addr_reg  <= if_addr;
            wr_reg    <= 1'b0;
            wdata_reg <= '0;
          end
        end
        IFETCH: begin
          // mem_valid takes priority over a coincident timeout.
          if (mem_valid || tc) begin
            if_rdata_reg <= mem_valid ? mem_rdata : '0;
            if_done_reg  <= 1'b1;
            last_srv_reg <= FETCH;
            state_reg    <= TURN;
            if (!mem_valid) err_reg <= 1'b1;
          end
        end
        DACC: begin
          if (mem_valid || tc) begin
            if (!wr_reg) d_rdata_reg <= mem_valid ? mem_rdata : '0;
            d_done_reg   <= 1'b1;
            last_srv_reg <= DATA;
            state_reg    <= TURN;
            if (!mem_valid) err_reg <= 1'b1;
          end
        end
        TURN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = busy;
  assign mem_wr    = busy && wr_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  assign if_rdata = if_rdata_reg;
  assign d_rdata  = d_rdata_reg;
  assign if_done  = if_done_reg;
  assign d_done   = d_done_reg;
  assign err      = err_reg;

  assign stall = (if_req && !if_done_reg) || (d_req && !d_done_reg);

endmodule
